mips32_ram_arbiter: RTL
=======================

// Module: mips32_ram_arbiter
// PURPOSE
//  Two-port round-robin arbiter in front of one MIPS32 block RAM. Typically port A is
//  instruction fetch and port B is load/store.
//  - Accepts at most one transaction per cycle, read or byte-laned write.
//  - Drives the RAM read address and write ports.
//  - Returns read data one cycle after grant, tagged to the winning port.
//  - Optional per-port lock holds ownership across multi-beat sequences.
// PARAMETERS
//  AWIDTH  12  word address width; must match the RAM instance
//  DWIDTH  32  data width; must be a multiple of 8
//  LANES    4  byte lanes; must equal DWIDTH/8
// PORTS
//  clock          in   1       sole clock, rising edge
//  reset          in   1       synchronous, active-high
//  aReq/bReq      in   1       port requests a transaction this cycle
//  aLock/bLock    in   1       keep grant after this beat (sampled only when granted)
//  aAddr/bAddr    in   AWIDTH  word address
//  aWData/bWData  in   DWIDTH  write data
//  aLane/bLane    in   LANES   byte write enables; all zero = read
//  aGnt/bGnt      out  1       transaction accepted this cycle (combinational)
//  aRValid/bRValid out 1       rdata valid for the port's read granted last cycle
//  rData          out  DWIDTH  read data, shared by both ports; qualify with *RValid
//  ramReadAddr    out  AWIDTH  to RAM readAddr
//  ramReadData    in   DWIDTH  from RAM readData; RAM registers the address, 1-cycle latency
//  ramWriteAddr   out  AWIDTH  to RAM writeAddr
//  ramWriteData   out  DWIDTH  to RAM writeData
//  ramWriteLane   out  LANES   to RAM writeLane
//  ramWriteEnable out  1       to RAM writeEnable; 1 when a write is granted
// BEHAVIOUR
//  State:
//  - last: port granted most recently; reset value B, so A wins the first tie.
//  - owner: {NONE, A, B}; reset value NONE.
//  - rdPend[1:0]: per-port read-in-flight flags; reset value 0.
//  Grant (combinational from state and inputs):
//  - owner=A: aGnt = aReq, bGnt = 0. Symmetric for owner=B.
//  - owner=NONE, exactly one request: that port is granted.
//  - owner=NONE, both request: grant the port that is not 'last'.
//  - During reset: aGnt = bGnt = 0, ramWriteEnable = 0, ramWriteLane = 0.
//  RAM drive:
//  - ramReadAddr, ramWriteAddr, ramWriteData are muxed from the granted port.
//  - With no grant, the mux selects A and ramWriteLane = 0.
//  - Write: ramWriteLane = granted lanes; ramWriteEnable = |lanes.
//  - Read: ramWriteLane = 0, ramWriteEnable = 0.
//  Clock-edge updates:
//  - On any grant: last <= granted port.
//  - On a grant with lock=1: owner <= granted port.
//  - On a grant with lock=0: owner <= NONE.
//  - Owner with req=0: owner is held; the owning port may idle without losing ownership.
//  - Owner deasserts lock on a beat: that is the final beat; round-robin resumes next cycle.
//  - rdPend[p] <= read granted to p this cycle. *RValid = rdPend; rData = ramReadData.
//  Latency and throughput:
//  - Read: grant in cycle N, RValid and data in N+1.
//  - Back-to-back reads give one word per cycle.
//  - Write is committed at the edge ending its grant cycle.
//  - Read of the same address granted in the next cycle returns the new data; no bypass needed.
//  Other rules:
//  - A requester holds req/addr/data/lane stable until it sees gnt.
//  - gnt never depends on *RValid.
//  - Lock asserted while not granted is ignored.
//  - Reset mid-sequence clears owner and pending reads; no RValid in the cycle after reset.
//  - Address width and wrap are the RAM's concern; the arbiter passes addresses unchanged.
// TESTING
//  - Single read: reset, write mem[5]=0x11223344; aReq read addr 5 -> aGnt same cycle,
//    aRValid next cycle, rData=0x11223344.
//  - Tie: aReq and bReq held for 4 cycles, both reads -> grants A,B,A,B;
//    each RValid one cycle after its grant.
//  - Byte lanes: mem[3]=0xAABBCCDD; B writes 0x00001100 with lane 4'b0010;
//    A then reads 3 -> 0xAABB11DD.
//  - Lock: B granted with bLock=1 for 3 beats while aReq is held -> aGnt=0 for all 3 beats.
//    B's 4th beat has lock=0 -> it is granted; A is granted the cycle after.
//  - Write then read: A writes addr 9 = 0xDEADBEEF, B reads addr 9 the next cycle
//    -> bRValid with 0xDEADBEEF.
//  - Reset mid-op: assert reset the cycle after a read grant -> aRValid=bRValid=0,
//    owner cleared, first post-reset tie grants A.

Source files
------------

// File: rtl/mips32_ram_arbiter.sv
`default_nettype none
// ============================================================================
// mips32_ram_arbiter : two-port round-robin arbiter with per-port lock in front
//                      of a single MIPS32 block RAM (1-cycle read latency).
// Revision 1.0
// ============================================================================
module mips32_ram_arbiter #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32,
  parameter int LANES  = 4
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              aReq,
  input  logic              aLock,
  input  logic [AWIDTH-1:0] aAddr,
  input  logic [DWIDTH-1:0] aWData,
  input  logic [LANES-1:0]  aLane,
  output logic              aGnt,
  output logic              aRValid,

  input  logic              bReq,
  input  logic              bLock,
  input  logic [AWIDTH-1:0] bAddr,
  input  logic [DWIDTH-1:0] bWData,
  input  logic [LANES-1:0]  bLane,
  output logic              bGnt,
  output logic              bRValid,

  output logic [DWIDTH-1:0] rData,

  output logic [AWIDTH-1:0] ramReadAddr,
  input  logic [DWIDTH-1:0] ramReadData,
  output logic [AWIDTH-1:0] ramWriteAddr,
  output logic [DWIDTH-1:0] ramWriteData,
  output logic [LANES-1:0]  ramWriteLane,
  output logic              ramWriteEnable
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  owner_t     owner;
  logic       last_b;
  logic [1:0] rd_pend;

  logic             a_gnt;
  logic             b_gnt;
  logic [LANES-1:0] gnt_lane;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      case (owner)
        OWN_A:   a_gnt = aReq;
        OWN_B:   b_gnt = bReq;
        default: begin
          // Tie goes to whichever port did not win most recently.
          if (aReq && bReq) begin
            a_gnt = last_b;
            b_gnt = !last_b;
          end else begin
            a_gnt = aReq;
            b_gnt = bReq;
          end
        end
      endcase
    end
  end

  always_comb begin
    gnt_lane = '0;
    if (a_gnt)      gnt_lane = aLane;
    else if (b_gnt) gnt_lane = bLane;
  end

  // Address/data mux defaults to port A when nothing is granted.
  assign ramReadAddr    = b_gnt ? bAddr  : aAddr;
  assign ramWriteAddr   = b_gnt ? bAddr  : aAddr;
  assign ramWriteData   = b_gnt ? bWData : aWData;
  assign ramWriteLane   = gnt_lane;
  assign ramWriteEnable = |gnt_lane;

  assign aGnt    = a_gnt;
  assign bGnt    = b_gnt;
  assign aRValid = rd_pend[0];
  assign bRValid = rd_pend[1];
  assign rData   = ramReadData;

  always_ff @(posedge clock) begin
    if (reset) begin
      owner   <= OWN_NONE;
      last_b  <= 1'b1;
      rd_pend <= 2'b00;
    end else begin
      rd_pend[0] <= a_gnt && (aLane == '0);
      rd_pend[1] <= b_gnt && (bLane == '0);
      // An owner that idles keeps ownership: no grant means no update here.
      if (a_gnt) begin
        last_b <= 1'b0;
        owner  <= aLock ? OWN_A : OWN_NONE;
      end else if (b_gnt) begin
        last_b <= 1'b1;
        owner  <= bLock ? OWN_B : OWN_NONE;
      end
    end
  end

endmodule
`default_nettype wire
